// File: rtl/program_counter_unit_if.sv
// Fetch-stage bus between the control unit and the program counter unit:
// decode controls in, PC/next-PC and return-stack status out.
interface program_counter_unit_if #(
    parameter int ADDR_WIDTH  = 11,
    parameter int STACK_DEPTH = 8
);
    localparam int SDW = $clog2(STACK_DEPTH + 1);

    logic                  EN;
    logic                  ILO;
    logic                  BO;
    logic                  CALL;
    logic                  RET;
    logic [ADDR_WIDTH-1:0] IADDR;
    logic [ADDR_WIDTH-1:0] PC;
    logic [ADDR_WIDTH-1:0] NPC;
    logic [SDW-1:0]        SDEPTH;
    logic                  SFULL;
    logic                  SEMPTY;
    logic                  ERR;

    modport master (
        output EN, ILO, BO, CALL, RET, IADDR,
        input  PC, NPC, SDEPTH, SFULL, SEMPTY, ERR
    );

    modport slave (
        input  EN, ILO, BO, CALL, RET, IADDR,
        output PC, NPC, SDEPTH, SFULL, SEMPTY, ERR
    );
endinterface

// File: rtl/program_counter_unit.sv
// Registered program counter with increment/branch/call/return decode and a
// LIFO return-address stack; reports stack occupancy and a sticky fault.
module program_counter_unit #(
    parameter int                    ADDR_WIDTH  = 11,
    parameter int                    STACK_DEPTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    program_counter_unit_if.slave  pcu
);
    localparam int SDW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = $clog2(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [SDW-1:0]        r_sdepth;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [ADDR_WIDTH-1:0] w_npc;
    logic [ADDR_WIDTH-1:0] w_top;
    logic [SDW-1:0]        w_sdepth_dec;
    logic [IW-1:0]         w_push_idx;
    logic [IW-1:0]         w_pop_idx;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fault;

    // Natural-width add: all-ones wraps to zero, also for the pushed return address.
    assign w_pc_inc     = r_pc + ADDR_WIDTH'(1);
    assign w_full       = (r_sdepth == SDW'(STACK_DEPTH));
    assign w_empty      = (r_sdepth == '0);
    assign w_sdepth_dec = r_sdepth - SDW'(1);
    assign w_push_idx   = r_sdepth[IW-1:0];
    assign w_pop_idx    = w_sdepth_dec[IW-1:0];
    assign w_top        = r_stack[w_pop_idx];

    always_comb begin
        w_npc   = w_pc_inc;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_fault = 1'b0;
        if (pcu.RET) begin
            if (!w_empty) begin
                w_npc = w_top;
                w_pop = 1'b1;
            end else begin
                w_fault = 1'b1;
            end
        end else if (pcu.CALL) begin
            if (!w_full) begin
                w_npc  = pcu.IADDR;
                w_push = 1'b1;
            end else begin
                w_fault = 1'b1;
            end
        end else if (pcu.ILO && pcu.BO) begin
            w_npc = pcu.IADDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc     <= RESET_ADDR;
            r_sdepth <= '0;
            r_err    <= 1'b0;
        end else if (pcu.EN) begin
            r_pc <= w_npc;
            if (w_push) begin
                r_sdepth <= r_sdepth + SDW'(1);
            end else if (w_pop) begin
                r_sdepth <= w_sdepth_dec;
            end
            if (w_fault) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stack contents carry no reset; only the depth pointer defines validity.
    always_ff @(posedge CLK) begin
        if (!RST && pcu.EN && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign pcu.PC     = r_pc;
    assign pcu.NPC    = w_npc;
    assign pcu.SDEPTH = r_sdepth;
    assign pcu.SFULL  = w_full;
    assign pcu.SEMPTY = w_empty;
    assign pcu.ERR    = r_err;
endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
Registered program-counter unit for the processor fetch stage. It holds the current PC and computes the next PC each enabled cycle: sequential increment, conditional branch/load, subroutine CALL with a return-address stack, or RET. It replaces the purely combinational next-address path with one sequential block that also reports stack status and faults to the control unit.

Parameters:
ADDR_WIDTH, 11, width of PC, IADDR, NPC and return addresses
STACK_DEPTH, 8, number of return-address entries (>=2)
RESET_ADDR, 0, PC value loaded on reset

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
EN  input  1  advance enable; 0 = stall, all state held
ILO  input  1  increment/load select: 0 increment, 1 load
BO  input  1  branch condition; qualifies a load when ILO=1
CALL  input  1  subroutine call: push return address, jump to IADDR
RET  input  1  return: pop stack top into PC
IADDR  input  ADDR_WIDTH  target address for load/branch/call
PC  output  ADDR_WIDTH  registered current program counter
NPC  output  ADDR_WIDTH  combinational next-PC value (what PC takes at next enabled edge)
SDEPTH  output  $clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH
SFULL  output  1  SDEPTH == STACK_DEPTH
SEMPTY  output  1  SDEPTH == 0
ERR  output  1  sticky fault: overflow or underflow attempted

Behaviour:
- Reset (RST=1 at edge, regardless of EN): PC=RESET_ADDR, SDEPTH=0, SEMPTY=1, SFULL=0, ERR=0; stack contents don't-care. Reset wins over every other input.
- EN=0: PC, stack, SDEPTH, ERR held; NPC still reflects the decode, which has no effect.
- Decode priority when EN=1 (first match wins):
  1. RET=1, stack non-empty: NPC=top entry; pop (SDEPTH-1). CALL ignored.
  2. RET=1, stack empty: NPC=PC+1, stack unchanged, ERR<=1.
  3. CALL=1, stack not full: NPC=IADDR; push PC+1 (SDEPTH+1).
  4. CALL=1, stack full: NPC=PC+1, stack unchanged, ERR<=1.
  5. ILO=1 and BO=1: NPC=IADDR.
  6. Otherwise, including ILO=1 with BO=0 and ILO=0: NPC=PC+1.
- PC<=NPC at the enabled edge: one-cycle latency from inputs to PC.
- Arithmetic: PC+1 is computed modulo 2^ADDR_WIDTH; all-ones wraps to 0 with no flag. The pushed return address wraps the same way.
- Stack: LIFO. The pointer equals SDEPTH. A push writes entry[SDEPTH]. A pop reads entry[SDEPTH-1]. Only one push or pop happens per cycle.
- SFULL, SEMPTY and SDEPTH are registered-consistent: they are derived from SDEPTH and update the same edge as the push or pop.
- ERR is sticky: once set, it clears only on RST. Faulting operations never corrupt the stack.
- X on control inputs when EN=0 must not affect state.

Test Plan:
- Reset/increment: RST=1 for 1 cycle, then EN=1, ILO=0 for 3 cycles -> PC=0,1,2,3; SEMPTY=1, ERR=0.
- Branch/stall: PC=5, ILO=1, BO=0 -> PC=6. Then ILO=1, BO=1, IADDR=0x200 -> PC=0x200. Then EN=0 for 2 cycles with CALL=1 -> PC stays 0x200, SDEPTH=0.
- Call/return nesting: PC=0x010, CALL with IADDR=0x100 -> PC=0x100, SDEPTH=1. CALL with IADDR=0x300 -> PC=0x300, SDEPTH=2. RET -> PC=0x101. RET -> PC=0x011, SEMPTY=1, ERR=0.
- Overflow/underflow: 8 CALLs -> SFULL=1. A 9th CALL from PC=0x050 -> PC=0x051, SDEPTH=8, ERR=1. 8 RETs return the correct LIFO addresses. A further RET -> PC increments and ERR stays 1.
- Wrap and simultaneous events: PC=0x7FF with increment -> PC=0x000. PC=0x7FF with CALL to 0x020 -> pushes 0x000. With 1 entry, CALL+RET together -> RET wins, PC=popped value, SDEPTH=0.
- Reset mid-operation: SDEPTH=3, ERR=1, assert RST with CALL=1 -> next cycle PC=RESET_ADDR, SDEPTH=0, ERR=0, no push.
